// File: rtl/lab5_pkg.sv
// Shared constants, FSM state type and the accumulator-to-sample
// saturate/truncate helper for the time-shared 3-tap FIR.
package lab5_pkg;

  localparam int DW = 10;
  localparam int CW = 12;
  localparam int AW = 26;

  localparam logic signed [CW-1:0] K1 = 12'hC00;
  localparam logic signed [CW-1:0] K2 = 12'h500;
  localparam logic signed [CW-1:0] K3 = 12'hC00;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAC0 = 3'd1,
    MAC1 = 3'd2,
    MAC2 = 3'd3,
    OUT  = 3'd4
  } state_e;

  // 4.22 -> 1.9: keep [22:13] (floor), clamp when the integer bits disagree.
  function automatic logic [DW-1:0] sat_trunc(input logic [AW-1:0] a);
    logic [3:0] top;
    top = a[AW-1:AW-4];
    if ((&top) || !(|top)) begin
      sat_trunc = a[AW-4:AW-3-DW];
    end else if (a[AW-1]) begin
      sat_trunc = {1'b1, {(DW-1){1'b0}}};
    end else begin
      sat_trunc = {1'b0, {(DW-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/lab5_mac_unit.sv
// Single signed CW x CW multiplier feeding an AW-bit accumulator register.
// clr_acc loads the product instead of adding it; flush zeroes the register.
module lab5_mac_unit
  import lab5_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 en,
  input  logic                 clr_acc,
  input  logic signed [CW-1:0] a,
  input  logic signed [CW-1:0] b,
  output logic [AW-1:0]        acc,
  output logic [AW-1:0]        prod
);

  logic signed [2*CW-1:0] prod_s;
  logic [AW-1:0]          acc_d;
  logic [AW-1:0]          acc_q;

  // Product sign-extension and accumulator next value.
  always_comb begin
    prod_s = a * b;
    prod   = {{(AW-2*CW){prod_s[2*CW-1]}}, prod_s};
    acc_d  = acc_q;
    if (flush) begin
      acc_d = {AW{1'b0}};
    end else if (en) begin
      if (clr_acc) begin
        acc_d = prod;
      end else begin
        acc_d = acc_q + prod;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= {AW{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/lab5_fir_seq.sv
// Sequenced 3-tap FIR: one shared MAC walks the delay line over three
// cycles, then holds the saturated result until the consumer takes it.
module lab5_fir_seq
  import lab5_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] y,
  output logic          busy
);

  state_e               state_q, state_d;
  logic [DW-1:0]        x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
  logic [DW-1:0]        y_q, y_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_s;
  logic                 mac_en_s, mac_clr_s;
  logic signed [CW-1:0] coef_s, opnd_s;
  logic [AW-1:0]        acc_s, prod_s, sum_s;

  // Coefficient and operand selection follow the state only.
  always_comb begin
    coef_s = K1;
    opnd_s = {x1_q, 2'b00};
    case (state_q)
      MAC0:    begin coef_s = K1; opnd_s = {x1_q, 2'b00}; end
      MAC1:    begin coef_s = K2; opnd_s = {x2_q, 2'b00}; end
      MAC2:    begin coef_s = K3; opnd_s = {x3_q, 2'b00}; end
      default: begin coef_s = K1; opnd_s = {x1_q, 2'b00}; end
    endcase
  end

  lab5_mac_unit u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (clear),
    .en      (mac_en_s),
    .clr_acc (mac_clr_s),
    .a       (coef_s),
    .b       (opnd_s),
    .acc     (acc_s),
    .prod    (prod_s)
  );

  assign sum_s = acc_s + prod_s;

  // Next-state, delay-line shift and output-register control.
  always_comb begin
    state_d     = state_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    x3_d        = x3_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    in_ready_s  = 1'b0;
    mac_en_s    = 1'b0;
    mac_clr_s   = 1'b0;
    if (clear) begin
      state_d     = IDLE;
      x1_d        = {DW{1'b0}};
      x2_d        = {DW{1'b0}};
      x3_d        = {DW{1'b0}};
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_s = 1'b1;
          if (in_valid) begin
            x3_d    = x2_q;
            x2_d    = x1_q;
            x1_d    = x_in;
            state_d = MAC0;
          end else begin
            state_d = IDLE;
          end
        end
        MAC0: begin
          mac_en_s  = 1'b1;
          mac_clr_s = 1'b1;
          state_d   = MAC1;
        end
        MAC1: begin
          mac_en_s = 1'b1;
          state_d  = MAC2;
        end
        MAC2: begin
          y_d         = sat_trunc(sum_s);
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
        OUT: begin
          in_ready_s = out_ready;
          if (out_ready) begin
            out_valid_d = 1'b0;
            if (in_valid) begin
              x3_d    = x2_q;
              x2_d    = x1_q;
              x1_d    = x_in;
              state_d = MAC0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = OUT;
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State, delay line and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x1_q        <= {DW{1'b0}};
      x2_q        <= {DW{1'b0}};
      x3_q        <= {DW{1'b0}};
      y_q         <= {DW{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      x3_q        <= x3_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_s & rst_n;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign busy      = (state_q == MAC0) || (state_q == MAC1) || (state_q == MAC2);

endmodule

// File: doc/lab5_fir_seq.md
Name: lab5_fir_seq

Overview:
- Sequencer that time-shares one 12x12 signed multiplier and accumulator to compute y = k1*x1 + k2*x2 + k3*x3 over a 3-sample delay line, a 3-tap FIR.
- It replaces the fully parallel three-multiplier datapath when area matters.
- Samples arrive on a valid/ready input stream; results leave on a valid/ready output stream.

Parameters:
- DW, 10, sample and result width (signed, 1.9 fixed point)
- CW, 12, coefficient width (signed, 1.11 fixed point)
- AW, 26, accumulator width (signed, 4.22)
- K1, 12'hC00, tap-1 coefficient (-0.5), applied to newest sample
- K2, 12'h500, tap-2 coefficient (0.625)
- K3, 12'hC00, tap-3 coefficient (-0.5), applied to oldest sample

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush: zero delay line, abort computation
- in_valid  in  1  x_in holds a sample
- in_ready  out  1  block accepts a sample this cycle
- x_in  in  DW  signed input sample
- out_valid  out  1  y holds a result
- out_ready  in  1  consumer takes y this cycle
- y  out  DW  signed filtered result
- busy  out  1  high in MAC0..MAC2

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - Delay line x1,x2,x3 and acc are 0.
  - y=0, out_valid=0, busy=0, in_ready=0 while reset is asserted.
- Reset mid-operation aborts immediately; no output is produced for the in-flight sample.
- States: IDLE, MAC0, MAC1, MAC2, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: x3<=x2, x2<=x1, x1<=x_in; go to MAC0.
- MAC0: acc <= K1*x1 (acc overwritten, not added); go to MAC1.
- MAC1: acc <= acc + K2*x2; go to MAC2.
- MAC2: acc + K3*x3 is formed, saturated and registered into y; out_valid<=1; go to OUT.
- OUT:
  - out_valid held; y stable until handshake.
  - in_ready = out_ready.
  - out_ready && in_valid: handshake completes and the new sample is accepted in the same edge; go to MAC0, out_valid<=0.
  - out_ready && !in_valid: go to IDLE, out_valid<=0.
  - !out_ready: stay in OUT. in_ready=0, input is back-pressured.
- Latency: sample accepted at edge N; out_valid=1 after edge N+3.
- Throughput: one sample per 4 cycles when the consumer is always ready.
- Arithmetic:
  - Multiplier operand = {x, 2'b00}, i.e. 1.9 converted to 1.11.
  - Product is a 24-bit signed 2.22 value, sign-extended to AW before accumulation.
  - Result = acc[22:13], truncation toward -inf.
  - If acc[25:22] are not all equal, saturate: 10'h1FF if positive, 10'h200 if negative.
- clear:
  - Zeroes the delay line and acc, sets out_valid=0, state=IDLE.
  - Has priority over any handshake in the same cycle.
  - A sample presented in the same cycle is not accepted (in_ready forced 0 while clear=1).
- The delay line starts at zero, so the first two results after reset or clear use zero history.
- Coefficient select and operand mux are driven from the state; there are no combinational paths from in_valid to out_valid.

Decomposition:
- Package lab5_pkg holds:
  - DW, CW, AW and K1..K3 constants
  - state enum type (IDLE, MAC0, MAC1, MAC2, OUT)
  - a saturate/truncate function AW->DW
- Sub-module lab5_mac_unit:
  - Signed CW x CW multiply.
  - Inputs: clr_acc (load vs accumulate) and en.
  - Output: registered AW-bit acc.
- lab5_fir_seq holds the FSM, delay line, operand/coefficient muxes and the output register.

Test Plan:
1. After reset, feed x_in=10'h100 three times with out_ready=1. Results must be y=10'h380 (-0.25), then 10'h020 (+0.0625), then 10'h3A0 (-0.1875). Each out_valid appears exactly 3 edges after acceptance.
2. Feed 10'h200, 10'h1FF, 10'h200 -> third y=10'h1FF (positive saturation). Then clear and feed 10'h1FF, 10'h200, 10'h1FF -> third y=10'h200 (negative saturation).
3. Hold out_ready=0 for 6 cycles with in_valid=1:
   - in_ready=0 and y stable throughout.
   - Raise out_ready: the next sample is accepted on that same edge and out_valid drops the next cycle.
4. Continuous in_valid=1, out_ready=1 over 8 samples -> one acceptance every 4 cycles, results match a software FIR model.
5. Deassert rst_n during MAC1 -> all outputs 0 immediately. After release, feeding 10'h100 gives y=10'h380, proving the delay line was zeroed.
6. Assert clear in the same cycle as in_valid in IDLE -> sample not accepted, in_ready=0. Next sample 10'h100 gives y=10'h380.
